// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_arb_pkg : shared state encoding and requester ids for mem_port_arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_GRANT_I = 2'b01;
   localparam logic [1:0] ST_GRANT_D = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      GRANT_I = ST_GRANT_I,
      GRANT_D = ST_GRANT_D
   } arb_state_e;

   localparam int NUM_REQ = 2;
   localparam int REQ_I   = 0;
   localparam int REQ_D   = 1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : requester and memory-side signals of the arbiter.
// master = arbiter view, slave = requesters + memory view.  Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_pick.sv
// ============================================================================
// arb_pick : combinational winner select between I and D requesters.
// D has priority unless the I-priority override is raised.  Revision: 1.0
// ============================================================================
`default_nettype none

module arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] elig_i,
   input  logic               i_prio_i,
   output logic               grant_i_o,
   output logic               grant_d_o
);

   always_comb begin
      grant_i_o = 1'b0;
      grant_d_o = 1'b0;
      if (elig_i[REQ_I] && i_prio_i) begin
         grant_i_o = 1'b1;
      end else if (elig_i[REQ_D]) begin
         grant_d_o = 1'b1;
      end else if (elig_i[REQ_I]) begin
         grant_i_o = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-port memory between fetch (I) and
// MEM stage (D). Optional macro ARB_FAIR_EN bounds D wins while I waits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_DWIN = 4
) (
   input  logic               clock,
   input  logic               reset,
   mem_port_arbiter_if.master arb_io
);

   arb_state_e    state_q, state_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          i_ack_q, i_ack_d;
   logic          d_ack_q, d_ack_d;

   logic w_i_elig, w_d_elig, w_turn, w_i_prio, w_grant_i, w_grant_d;

   // A req seen in its own ack cycle is the retiring request; any ack cycle is a turnaround.
   assign w_i_elig = arb_io.i_req & ~i_ack_q;
   assign w_d_elig = arb_io.d_req & ~d_ack_q;
   assign w_turn   = i_ack_q | d_ack_q;

   arb_pick u_pick (
      .elig_i    ({w_d_elig, w_i_elig}),
      .i_prio_i  (w_i_prio),
      .grant_i_o (w_grant_i),
      .grant_d_o (w_grant_d)
   );

`ifdef ARB_FAIR_EN
   localparam int            CNT_W      = $clog2(MAX_DWIN + 2);
   localparam logic [CNT_W-1:0] DWIN_LIMIT = CNT_W'(MAX_DWIN);

   logic [CNT_W-1:0] fair_cnt_q, fair_cnt_d;

   always_comb begin
      fair_cnt_d = fair_cnt_q;
      if (state_q == IDLE) begin
         if (!arb_io.i_req) begin
            fair_cnt_d = '0;
         end else if (!w_turn && w_grant_i) begin
            fair_cnt_d = '0;
         end else if (!w_turn && w_grant_d && (fair_cnt_q != DWIN_LIMIT)) begin
            fair_cnt_d = fair_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fair_cnt_q <= '0;
      end else begin
         fair_cnt_q <= fair_cnt_d;
      end
   end

   assign w_i_prio = (fair_cnt_q == DWIN_LIMIT);
`else
   // Strict D priority; the window size has no effect in this build.
   assign w_i_prio = (MAX_DWIN < 0);
`endif

   always_comb begin
      state_d     = state_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_turn && w_grant_d) begin
               state_d     = GRANT_D;
               mem_we_d    = arb_io.d_we;
               mem_addr_d  = arb_io.d_addr;
               mem_wdata_d = arb_io.d_wdata;
            end else if (!w_turn && w_grant_i) begin
               state_d     = GRANT_I;
               mem_we_d    = 1'b0;
               mem_addr_d  = arb_io.i_addr;
               mem_wdata_d = '0;
            end
         end
         GRANT_I: begin
            if (arb_io.mem_ready) begin
               i_rdata_d = arb_io.mem_rdata;
               i_ack_d   = 1'b1;
               state_d   = IDLE;
            end
         end
         GRANT_D: begin
            if (arb_io.mem_ready) begin
               if (!mem_we_q) begin
                  d_rdata_d = arb_io.mem_rdata;
               end
               d_ack_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
      end
   end

   assign arb_io.mem_req   = (state_q != IDLE);
   assign arb_io.mem_we    = mem_we_q;
   assign arb_io.mem_addr  = mem_addr_q;
   assign arb_io.mem_wdata = mem_wdata_q;
   assign arb_io.i_rdata   = i_rdata_q;
   assign arb_io.d_rdata   = d_rdata_q;
   assign arb_io.i_ack     = i_ack_q;
   assign arb_io.d_ack     = d_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed vector table, random traffic against a
// transaction-level model, starvation/fairness and reset-mid-grant sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int MAX_DWIN = 4;
`ifdef ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_DWIN(MAX_DWIN)) dut (
      .clock  (clock),
      .reset  (reset),
      .arb_io (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          ir;  logic [31:0] ia;
      bit          dr;  bit dw; logic [31:0] da; logic [31:0] dd;
      bit          rdy; logic [31:0] rd;
      bit          emr; bit emw; logic [31:0] ema; logic [31:0] emd;
      bit          eia; bit eda; logic [31:0] eir; logic [31:0] edr;
   } vec_t;

   vec_t vec [24];

   function automatic vec_t mk(bit ir, logic [31:0] ia, bit dr, bit dw, logic [31:0] da,
                               logic [31:0] dd, bit rdy, logic [31:0] rd, bit emr, bit emw,
                               logic [31:0] ema, logic [31:0] emd, bit eia, bit eda,
                               logic [31:0] eir, logic [31:0] edr);
      vec_t v;
      v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.rdy = rdy; v.rd = rd;
      v.emr = emr; v.emw = emw; v.ema = ema; v.emd = emd;
      v.eia = eia; v.eda = eda; v.eir = eir; v.edr = edr;
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs(input string tag, input bit mr, input bit mw, input logic [31:0] ma,
                           input logic [31:0] md, input bit ia, input bit da,
                           input logic [31:0] ir, input logic [31:0] dr);
      chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(mr));
      if (mr) begin
         chk({tag, ".mem_we"},    32'(bus.mem_we), 32'(mw));
         chk({tag, ".mem_addr"},  bus.mem_addr,    ma);
         chk({tag, ".mem_wdata"}, bus.mem_wdata,   md);
      end
      chk({tag, ".i_ack"},   32'(bus.i_ack), 32'(ia));
      chk({tag, ".d_ack"},   32'(bus.d_ack), 32'(da));
      chk({tag, ".i_rdata"}, bus.i_rdata,    ir);
      chk({tag, ".d_rdata"}, bus.d_rdata,    dr);
   endtask

   task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] dd, input bit rdy,
                        input logic [31:0] rd);
      bus.i_req = ir; bus.i_addr = ia;
      bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
      bus.mem_ready = rdy; bus.mem_rdata = rd;
   endtask

   // Reference model: one outstanding memory transaction, ack the cycle after completion
   bit          m_busy, m_own_d, m_we, m_ack_i, m_ack_d;
   logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
   int          m_dwin;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int  n_d_before, n_i, n_d_total, after_kind;
      bit  ack_cycle, take_i;
      checks   = 0;
      failures = 0;

      vec[0]  = mk(1,'h40,0,0,0,0,0,0,                 0,0,0,0,                 0,0,0,0);
      vec[1]  = mk(1,'h40,0,0,0,0,1,'h20010005,        1,0,'h40,0,              0,0,0,0);
      vec[2]  = mk(0,0,0,0,0,0,0,0,                    0,0,0,0,                 1,0,'h20010005,0);
      vec[3]  = mk(0,0,0,0,0,0,0,0,                    0,0,0,0,                 0,0,'h20010005,0);
      vec[4]  = mk(1,'h100,1,1,'h80,'hDEADBEEF,0,0,    0,0,0,0,                 0,0,'h20010005,0);
      vec[5]  = mk(1,'h100,1,1,'h80,'hDEADBEEF,1,'hAAAA0000, 1,1,'h80,'hDEADBEEF, 0,0,'h20010005,0);
      vec[6]  = mk(1,'h100,0,0,0,0,0,0,                0,0,0,0,                 0,1,'h20010005,0);
      vec[7]  = mk(1,'h100,0,0,0,0,0,0,                0,0,0,0,                 0,0,'h20010005,0);
      vec[8]  = mk(1,'h100,0,0,0,0,1,'h0BADF00D,       1,0,'h100,0,             0,0,'h20010005,0);
      vec[9]  = mk(0,0,0,0,0,0,0,0,                    0,0,0,0,                 1,0,'h0BADF00D,0);
      vec[10] = mk(0,0,1,0,'h10,0,0,0,                 0,0,0,0,                 0,0,'h0BADF00D,0);
      vec[11] = mk(0,0,1,0,'h10,0,0,0,                 1,0,'h10,0,              0,0,'h0BADF00D,0);
      vec[12] = mk(0,0,1,0,'h10,0,0,0,                 1,0,'h10,0,              0,0,'h0BADF00D,0);
      vec[13] = mk(0,0,1,0,'h10,0,0,0,                 1,0,'h10,0,              0,0,'h0BADF00D,0);
      vec[14] = mk(0,0,1,0,'h10,0,1,'h12345678,        1,0,'h10,0,              0,0,'h0BADF00D,0);
      vec[15] = mk(0,0,0,0,0,0,0,0,                    0,0,0,0,                 0,1,'h0BADF00D,'h12345678);
      vec[16] = mk(1,'h200,0,0,0,0,0,0,                0,0,0,0,                 0,0,'h0BADF00D,'h12345678);
      vec[17] = mk(1,'h200,0,0,0,0,1,'h11112222,       1,0,'h200,0,             0,0,'h0BADF00D,'h12345678);
      vec[18] = mk(1,'h200,0,0,0,0,0,0,                0,0,0,0,                 1,0,'h11112222,'h12345678);
      vec[19] = mk(1,'h204,0,0,0,0,0,0,                0,0,0,0,                 0,0,'h11112222,'h12345678);
      vec[20] = mk(1,'h204,0,0,0,0,1,'h33334444,       1,0,'h204,0,             0,0,'h11112222,'h12345678);
      vec[21] = mk(0,0,0,0,0,0,0,0,                    0,0,0,0,                 1,0,'h33334444,'h12345678);
      vec[22] = mk(0,0,0,0,0,0,1,'hFFFFFFFF,           0,0,0,0,                 0,0,'h33334444,'h12345678);
      vec[23] = mk(0,0,0,0,0,0,0,0,                    0,0,0,0,                 0,0,'h33334444,'h12345678);

      // Reset state
      reset = 1'b1;
      drive(0,0,0,0,0,0,0,0);
      #12;
      chk_outs("reset", 0,0,0,0, 0,0,0,0);
      chk("reset.mem_addr",  bus.mem_addr,  0);
      chk("reset.mem_we",    32'(bus.mem_we), 0);
      chk("reset.mem_wdata", bus.mem_wdata, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Directed vectors
      for (int k = 0; k < 24; k++) begin
         chk_outs($sformatf("vec%0d", k), vec[k].emr, vec[k].emw, vec[k].ema, vec[k].emd,
                  vec[k].eia, vec[k].eda, vec[k].eir, vec[k].edr);
         drive(vec[k].ir, vec[k].ia, vec[k].dr, vec[k].dw, vec[k].da, vec[k].dd,
               vec[k].rdy, vec[k].rd);
         tick();
      end

      // Random traffic
      m_busy = 0; m_own_d = 0; m_we = 0; m_ack_i = 0; m_ack_d = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 'h33334444; m_drdata = 'h12345678; m_dwin = 0;
      for (int c = 0; c < 400; c++) begin
         chk_outs("rnd", m_busy, m_we, m_addr, m_wdata, m_ack_i, m_ack_d, m_irdata, m_drdata);
         chk("rnd.ack_excl", 32'(bus.i_ack & bus.d_ack), 0);
         if (!bus.i_req || bus.i_ack) begin
            bus.i_req  = ($urandom_range(0, 2) == 0);
            bus.i_addr = $urandom;
         end
         if (!bus.d_req || bus.d_ack) begin
            bus.d_req   = ($urandom_range(0, 3) == 0);
            bus.d_we    = $urandom_range(0, 1) == 1;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
         end
         bus.mem_ready = $urandom_range(0, 1) == 1;
         bus.mem_rdata = $urandom;

         if (m_busy) begin
            if (bus.mem_ready) begin
               m_busy = 0;
               if (m_own_d) begin
                  m_ack_d = 1;
                  if (!m_we) m_drdata = bus.mem_rdata;
               end else begin
                  m_ack_i  = 1;
                  m_irdata = bus.mem_rdata;
               end
            end
         end else begin
            ack_cycle = m_ack_i | m_ack_d;
            m_ack_i = 0;
            m_ack_d = 0;
            if (!bus.i_req) m_dwin = 0;
            if (!ack_cycle && (bus.i_req || bus.d_req)) begin
               take_i  = bus.i_req && (!bus.d_req || (FAIR && m_dwin >= MAX_DWIN));
               m_busy  = 1;
               m_own_d = !take_i;
               if (take_i) begin
                  m_we = 0; m_addr = bus.i_addr; m_wdata = 0; m_dwin = 0;
               end else begin
                  m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                  if (bus.i_req && m_dwin < MAX_DWIN) m_dwin++;
               end
            end
         end
         tick();
      end

      // Both requesters held continuously: starvation or bounded D window
      drive(0,0,0,0,0,0,1,0);
      repeat (5) tick();
      drive(1,'h400,1,0,'h500,0,1,'hCAFE0001);
      n_d_before = 0; n_i = 0; n_d_total = 0; after_kind = -1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (bus.d_ack) begin
            n_d_total++;
            if (n_i == 0) n_d_before++;
            else if (after_kind < 0) after_kind = 1;
         end
         if (bus.i_ack) begin
            if (n_i > 0 && after_kind < 0) after_kind = 0;
            n_i++;
         end
      end
      if (FAIR) begin
         chk("fair.d_acks_before_i", 32'(n_d_before), 32'(MAX_DWIN));
         chk("fair.i_granted",       32'(n_i > 0),     1);
         chk("fair.d_resumes",       32'(after_kind),  1);
      end else begin
         chk("strict.i_acks",        32'(n_i),         0);
         chk("strict.d_acks",        32'(n_d_total),   20);
      end

      // Reset in the middle of a D grant with the memory stalling
      drive(0,0,0,0,0,0,1,0);
      repeat (5) tick();
      drive(0,0,1,1,'h300,'h55AA55AA,0,0);
      tick();
      chk("rstmid.mem_req",  32'(bus.mem_req), 1);
      chk("rstmid.mem_we",   32'(bus.mem_we),  1);
      chk("rstmid.mem_addr", bus.mem_addr,     'h300);
      tick();
      chk("rstmid.wait_req", 32'(bus.mem_req), 1);
      #3;
      reset = 1'b1;
      #1;
      chk_outs("rstmid.async", 0,0,0,0, 0,0,0,0);
      chk("rstmid.addr_clr", bus.mem_addr, 0);
      chk("rstmid.we_clr",   32'(bus.mem_we), 0);
      bus.d_req = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk_outs("postrst", 0,0,0,0, 0,0,0,0);
         chk("postrst.mem_wdata", bus.mem_wdata, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the pipeline's instruction-fetch stage (I) and memory stage (D, lw/sw).
- Grants one requester at a time and sequences one memory transaction per grant.
- Returns read data and a one-cycle ack to the granted requester.
- The pipeline holds PC/IR (wpcir low) while i_req is high without i_ack, and holds the MEM stage while d_req is high without d_ack.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_DWIN, 4, consecutive D grants allowed while I is waiting (used only with ARB_FAIR_EN)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_req  in  1  instruction fetch request; held until i_ack
i_addr  in  AW  fetch address
i_rdata  out  DW  fetched word, valid when i_ack
i_ack  out  1  one-cycle completion pulse for I
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store (sw), 0 = load (lw)
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid when d_ack
d_ack  out  1  one-cycle completion pulse for D
mem_req  out  1  memory transaction active
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current transaction this cycle

Behaviour:
- Reset values (async, immediate): state=IDLE; mem_req, mem_we, i_ack, d_ack = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; fairness counter = 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - d_req eligible -> GRANT_D.
  - else i_req eligible -> GRANT_I.
  - else stay in IDLE.
- Eligible means the requester's req is high and its ack is not high in the same cycle. A req seen in its own ack cycle is the retiring request and is ignored.
- On entering GRANT_x, register the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata. I always uses we=0 and wdata=0.
- Requester inputs are not re-sampled during the grant.
- GRANT_x: mem_req=1.
  - mem_ready=0: hold state and all mem_* outputs.
  - mem_ready=1:
    - Capture mem_rdata into x_rdata; for a store, d_rdata keeps its old value.
    - Next cycle: x_ack=1, mem_req=0, state=IDLE.
- Latency: req sampled at edge 0, mem_req high in cycle 1, mem_ready in cycle k≥1, ack in cycle k+1.
  - Minimum 2 cycles req-to-ack.
  - Back-to-back minimum is 3 cycles per transaction: the ack/IDLE cycle is a turnaround cycle.
- x_rdata holds its value until the next completion for the same requester.
- i_ack and d_ack are never high together; each is high for exactly one cycle per transaction.
- mem_ready while IDLE is ignored (no ack, no capture).
- Requester drops req before ack (protocol violation): the transaction still completes and the ack is still issued. The bench flags this case; it is not recovered.
- d_req and i_req rising in the same cycle: D wins. I waits at least until D's ack cycle, then is granted if D is not re-requesting.
- Reset mid-grant: the transaction is abandoned, mem_req drops immediately, and no ack is issued after reset.

Optional Feature:
ARB_FAIR_EN:
- Defined:
  - A saturating counter counts D grants issued while i_req is pending.
  - When the counter = MAX_DWIN and I is eligible in IDLE, I wins over D.
  - The counter clears on every I grant and whenever i_req=0 in IDLE.
- Undefined: strict D priority; I may starve; no counter logic is present.

Decomposition:
- Package mem_arb_pkg:
  - state encoding localparams: IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10
  - requester id constants: REQ_I=0, REQ_D=1
- Sub-module arb_pick (optional):
  - combinational winner select from the eligible requests plus the fairness count
  - outputs grant_i and grant_d
- FSM, datapath registers and ack generation stay in mem_port_arbiter.

Test Plan:
1. Single I fetch: i_req=1, i_addr=0x0000_0040; mem_ready pulses in cycle 1 with mem_rdata=0x2001_0005 -> mem_req high for 1 cycle, mem_addr=0x40, mem_we=0; i_ack in cycle 2 with i_rdata=0x2001_0005; d_ack stays 0.
2. Simultaneous requests: i_req and d_req rise together, D is sw addr=0x80, wdata=0xDEAD_BEEF -> D granted first with mem_we=1, mem_wdata=0xDEADBEEF; d_ack; then I granted; i_ack 3 cycles after d_ack when mem_ready=1 each grant.
3. Wait states: D lw addr=0x10, mem_ready low 3 cycles then high with 0x1234_5678 -> mem_addr/mem_we stable all 4 grant cycles; d_ack at cycle 5; d_rdata=0x12345678.
4. Ack-cycle masking: requester keeps req high in its ack cycle -> no second grant from that stale req; a new req asserted in the cycle after ack is granted normally.
5. Reset mid-grant: assert reset during GRANT_D with mem_ready=0 -> mem_req=0 immediately; no d_ack; after release, state=IDLE and all outputs zero.
6. ARB_FAIR_EN, MAX_DWIN=4: d_req re-asserted continuously while i_req is held -> exactly 4 d_acks, then i_ack, then D resumes. Without the macro: i_ack never occurs while D keeps requesting.
